// File: rtl/fetch_stage_pkg.sv
// Shared Y86-64 encodings, widths and D-register payload for the fetch stage.
package fetch_stage_pkg;

    localparam int unsigned ADDR_W       = 64;
    localparam int unsigned IMEM_BYTES_W = 80;
    localparam int unsigned ICODE_W      = 4;
    localparam int unsigned REG_W        = 4;
    localparam int unsigned STAT_W       = 3;

    localparam logic [ICODE_W-1:0] I_HALT   = 4'h0;
    localparam logic [ICODE_W-1:0] I_NOP    = 4'h1;
    localparam logic [ICODE_W-1:0] I_RRMOVQ = 4'h2;
    localparam logic [ICODE_W-1:0] I_IRMOVQ = 4'h3;
    localparam logic [ICODE_W-1:0] I_RMMOVQ = 4'h4;
    localparam logic [ICODE_W-1:0] I_MRMOVQ = 4'h5;
    localparam logic [ICODE_W-1:0] I_OPQ    = 4'h6;
    localparam logic [ICODE_W-1:0] I_JXX    = 4'h7;
    localparam logic [ICODE_W-1:0] I_CALL   = 4'h8;
    localparam logic [ICODE_W-1:0] I_RET    = 4'h9;
    localparam logic [ICODE_W-1:0] I_PUSHQ  = 4'hA;
    localparam logic [ICODE_W-1:0] I_POPQ   = 4'hB;

    localparam logic [REG_W-1:0] RNONE = 4'hF;

    localparam logic [STAT_W-1:0] STAT_AOK = 3'd1;
    localparam logic [STAT_W-1:0] STAT_HLT = 3'd2;
    localparam logic [STAT_W-1:0] STAT_ADR = 3'd3;
    localparam logic [STAT_W-1:0] STAT_INS = 3'd4;

    typedef struct packed {
        logic [STAT_W-1:0]  stat;
        logic [ICODE_W-1:0] icode;
        logic [ICODE_W-1:0] ifun;
        logic [REG_W-1:0]   ra;
        logic [REG_W-1:0]   rb;
        logic [ADDR_W-1:0]  val_c;
        logic [ADDR_W-1:0]  val_p;
    } d_reg_t;

    // Value loaded on reset and on a bubble: an architecturally harmless NOP.
    localparam d_reg_t D_BUBBLE = '{
        stat:  STAT_AOK,
        icode: I_NOP,
        ifun:  4'h0,
        ra:    RNONE,
        rb:    RNONE,
        val_c: 64'h0,
        val_p: 64'h0
    };

    function automatic logic needs_regids(input logic [ICODE_W-1:0] icode);
        return icode inside {I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_OPQ, I_PUSHQ, I_POPQ};
    endfunction

    function automatic logic needs_val_c(input logic [ICODE_W-1:0] icode);
        return icode inside {I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_JXX, I_CALL};
    endfunction

endpackage

// File: rtl/fetch_split_align.sv
// Splits the 10-byte fetch window into icode/ifun, register ids and constant word.
module fetch_split_align
    import fetch_stage_pkg::*;
(
    input  logic [IMEM_BYTES_W-1:0] imem_data_i,
    input  logic                    imem_error_i,
    output logic [ICODE_W-1:0]      icode_o,
    output logic [ICODE_W-1:0]      ifun_o,
    output logic [REG_W-1:0]        ra_o,
    output logic [REG_W-1:0]        rb_o,
    output logic [ADDR_W-1:0]       val_c_o,
    output logic                    need_regids_o,
    output logic                    need_val_c_o,
    output logic                    instr_valid_o
);

    always_comb begin
        icode_o       = imem_data_i[7:4];
        ifun_o        = imem_data_i[3:0];
        ra_o          = RNONE;
        rb_o          = RNONE;
        val_c_o       = '0;
        need_regids_o = 1'b0;
        need_val_c_o  = 1'b0;
        instr_valid_o = 1'b0;

        // A faulted fetch is turned into a NOP so nothing downstream acts on garbage bytes.
        if (imem_error_i) begin
            icode_o = I_NOP;
            ifun_o  = 4'h0;
        end

        instr_valid_o = (icode_o <= I_POPQ);
        need_regids_o = needs_regids(icode_o);
        need_val_c_o  = needs_val_c(icode_o);

        if (need_regids_o) begin
            ra_o = imem_data_i[15:12];
            rb_o = imem_data_i[11:8];
        end

        // The constant follows the register byte when one is present.
        if (need_val_c_o) begin
            if (need_regids_o) begin
                val_c_o = imem_data_i[79:16];
            end else begin
                val_c_o = imem_data_i[71:8];
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: PC increment, next-PC prediction, status, and the F and D registers.
module fetch_stage
    import fetch_stage_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [ADDR_W-1:0]       f_pc_i,
    output logic [ADDR_W-1:0]       imem_addr_o,
    input  logic [IMEM_BYTES_W-1:0] imem_data_i,
    input  logic                    imem_error_i,
    input  logic                    F_stall_i,
    input  logic                    D_stall_i,
    input  logic                    D_bubble_i,
    output logic [ADDR_W-1:0]       F_predPC_o,
    output logic [STAT_W-1:0]       D_stat_o,
    output logic [ICODE_W-1:0]      D_icode_o,
    output logic [ICODE_W-1:0]      D_ifun_o,
    output logic [REG_W-1:0]        D_rA_o,
    output logic [REG_W-1:0]        D_rB_o,
    output logic [ADDR_W-1:0]       D_valC_o,
    output logic [ADDR_W-1:0]       D_valP_o
);

    logic [ICODE_W-1:0] icode;
    logic [ICODE_W-1:0] ifun;
    logic [REG_W-1:0]   ra;
    logic [REG_W-1:0]   rb;
    logic [ADDR_W-1:0]  val_c;
    logic               need_regids;
    logic               need_val_c;
    logic               instr_valid;

    logic [ADDR_W-1:0]  val_p;
    logic [ADDR_W-1:0]  pred_pc;
    logic [STAT_W-1:0]  stat;

    logic [ADDR_W-1:0]  f_pred_pc_d, f_pred_pc_q;
    d_reg_t             d_reg_d, d_reg_q;

    assign imem_addr_o = f_pc_i;

    fetch_split_align u_split (
        .imem_data_i   (imem_data_i),
        .imem_error_i  (imem_error_i),
        .icode_o       (icode),
        .ifun_o        (ifun),
        .ra_o          (ra),
        .rb_o          (rb),
        .val_c_o       (val_c),
        .need_regids_o (need_regids),
        .need_val_c_o  (need_val_c),
        .instr_valid_o (instr_valid)
    );

    // Instruction length and branch prediction (jumps always predicted taken).
    always_comb begin
        val_p = f_pc_i + ADDR_W'(1) + ADDR_W'(need_regids);
        if (need_val_c) begin
            val_p = val_p + ADDR_W'(8);
        end

        pred_pc = val_p;
        if (icode == I_JXX || icode == I_CALL) begin
            pred_pc = val_c;
        end
    end

    always_comb begin
        stat = STAT_AOK;
        if (imem_error_i) begin
            stat = STAT_ADR;
        end else if (!instr_valid) begin
            stat = STAT_INS;
        end else if (icode == I_HALT) begin
            stat = STAT_HLT;
        end
    end

    // Next-state for the F and D registers; stall wins over bubble.
    always_comb begin
        f_pred_pc_d = f_pred_pc_q;
        d_reg_d     = d_reg_q;

        if (!F_stall_i) begin
            f_pred_pc_d = pred_pc;
        end

        if (!D_stall_i) begin
            if (D_bubble_i) begin
                d_reg_d = D_BUBBLE;
            end else begin
                d_reg_d.stat  = stat;
                d_reg_d.icode = icode;
                d_reg_d.ifun  = ifun;
                d_reg_d.ra    = ra;
                d_reg_d.rb    = rb;
                d_reg_d.val_c = val_c;
                d_reg_d.val_p = val_p;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            f_pred_pc_q <= '0;
            d_reg_q     <= D_BUBBLE;
        end else begin
            f_pred_pc_q <= f_pred_pc_d;
            d_reg_q     <= d_reg_d;
        end
    end

    assign F_predPC_o = f_pred_pc_q;
    assign D_stat_o   = d_reg_q.stat;
    assign D_icode_o  = d_reg_q.icode;
    assign D_ifun_o   = d_reg_q.ifun;
    assign D_rA_o     = d_reg_q.ra;
    assign D_rB_o     = d_reg_q.rb;
    assign D_valC_o   = d_reg_q.val_c;
    assign D_valP_o   = d_reg_q.val_p;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized bench for fetch_stage against a byte-level reference model.
module tb_fetch_stage;

    logic        clk_i;
    logic        rst_n_i;
    logic [63:0] f_pc_i;
    logic [63:0] imem_addr_o;
    logic [79:0] imem_data_i;
    logic        imem_error_i;
    logic        F_stall_i;
    logic        D_stall_i;
    logic        D_bubble_i;
    logic [63:0] F_predPC_o;
    logic [2:0]  D_stat_o;
    logic [3:0]  D_icode_o;
    logic [3:0]  D_ifun_o;
    logic [3:0]  D_rA_o;
    logic [3:0]  D_rB_o;
    logic [63:0] D_valC_o;
    logic [63:0] D_valP_o;

    fetch_stage dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .f_pc_i       (f_pc_i),
        .imem_addr_o  (imem_addr_o),
        .imem_data_i  (imem_data_i),
        .imem_error_i (imem_error_i),
        .F_stall_i    (F_stall_i),
        .D_stall_i    (D_stall_i),
        .D_bubble_i   (D_bubble_i),
        .F_predPC_o   (F_predPC_o),
        .D_stat_o     (D_stat_o),
        .D_icode_o    (D_icode_o),
        .D_ifun_o     (D_ifun_o),
        .D_rA_o       (D_rA_o),
        .D_rB_o       (D_rB_o),
        .D_valC_o     (D_valC_o),
        .D_valP_o     (D_valP_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int passes = 0;

    logic [7:0] b [10];

    // Expected register contents.
    logic [63:0] e_pred;
    logic [2:0]  e_stat;
    logic [3:0]  e_icode, e_ifun, e_ra, e_rb;
    logic [63:0] e_valc, e_valp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic set_bytes(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3);
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        for (int k = 4; k < 10; k++) b[k] = 8'h00;
        for (int k = 0; k < 10; k++) imem_data_i[8*k +: 8] = b[k];
    endtask

    task automatic rand_bytes();
        for (int k = 0; k < 10; k++) begin
            b[k] = 8'($urandom);
            imem_data_i[8*k +: 8] = b[k];
        end
    endtask

    task automatic model_reset();
        e_pred = 64'h0; e_stat = 3'd1; e_icode = 4'h1; e_ifun = 4'h0;
        e_ra = 4'hF; e_rb = 4'hF; e_valc = 64'h0; e_valp = 64'h0;
    endtask

    // What a correct fetch of the current bytes/pc should produce.
    task automatic model_fetch(output logic [2:0] st, output logic [3:0] ic, output logic [3:0] ifn,
                               output logic [3:0] ra, output logic [3:0] rb,
                               output logic [63:0] vc, output logic [63:0] vp,
                               output logic [63:0] pp);
        int regs, cw;
        ic  = imem_error_i ? 4'h1 : b[0][7:4];
        ifn = imem_error_i ? 4'h0 : b[0][3:0];
        regs = (ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) ? 1 : 0;
        cw   = (ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8}) ? 1 : 0;
        ra = (regs == 1) ? b[1][7:4] : 4'hF;
        rb = (regs == 1) ? b[1][3:0] : 4'hF;
        vc = 64'h0;
        if (cw == 1)
            for (int k = 0; k < 8; k++) vc = vc | (64'(b[1 + regs + k]) << (8 * k));
        vp = f_pc_i + 64'(1 + regs + 8 * cw);
        pp = (ic == 4'h7 || ic == 4'h8) ? vc : vp;
        if (imem_error_i)       st = 3'd3;
        else if (ic > 4'hB)     st = 3'd4;
        else if (ic == 4'h0)    st = 3'd2;
        else                    st = 3'd1;
    endtask

    // One clock edge with the model updated alongside; leaves time at posedge+1.
    task automatic step();
        logic [2:0] st; logic [3:0] ic, ifn, ra, rb; logic [63:0] vc, vp, pp;
        model_fetch(st, ic, ifn, ra, rb, vc, vp, pp);
        @(posedge clk_i);
        if (!F_stall_i) e_pred = pp;
        if (!D_stall_i) begin
            if (D_bubble_i) begin
                e_stat = 3'd1; e_icode = 4'h1; e_ifun = 4'h0;
                e_ra = 4'hF; e_rb = 4'hF; e_valc = 64'h0; e_valp = 64'h0;
            end else begin
                e_stat = st; e_icode = ic; e_ifun = ifn;
                e_ra = ra; e_rb = rb; e_valc = vc; e_valp = vp;
            end
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/predPC"}, F_predPC_o, e_pred);
        chk({tag, "/stat"},   64'(D_stat_o),  64'(e_stat));
        chk({tag, "/icode"},  64'(D_icode_o), 64'(e_icode));
        chk({tag, "/ifun"},   64'(D_ifun_o),  64'(e_ifun));
        chk({tag, "/rA"},     64'(D_rA_o),    64'(e_ra));
        chk({tag, "/rB"},     64'(D_rB_o),    64'(e_rb));
        chk({tag, "/valC"},   D_valC_o, e_valc);
        chk({tag, "/valP"},   D_valP_o, e_valp);
    endtask

    task automatic ctl(input logic fs, input logic ds, input logic db);
        F_stall_i = fs; D_stall_i = ds; D_bubble_i = db;
    endtask

    initial begin
        rst_n_i = 1'b0; f_pc_i = 64'h0; imem_data_i = '0; imem_error_i = 1'b0;
        ctl(1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) b[k] = 8'h00;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // irmovq $0x10,%rbx
        f_pc_i = 64'h0; set_bytes(8'h30, 8'hF3, 8'h10, 8'h00);
        #1 chk("imem_addr", imem_addr_o, f_pc_i);
        step();
        check_all("irmovq");
        chk("irmovq/const_valP", D_valP_o, 64'hA);
        chk("irmovq/const_rB", 64'(D_rB_o), 64'h3);

        // jmp 0x100 and call 0x100
        f_pc_i = 64'h20; set_bytes(8'h70, 8'h00, 8'h01, 8'h00);
        step();
        check_all("jmp");
        chk("jmp/const_pred", F_predPC_o, 64'h100);
        chk("jmp/const_valP", D_valP_o, 64'h29);
        set_bytes(8'h80, 8'h00, 8'h01, 8'h00);
        step();
        check_all("call");
        chk("call/const_pred", F_predPC_o, 64'h100);

        // ret, halt, invalid, memory error
        f_pc_i = 64'h40; set_bytes(8'h90, 8'h12, 8'h34, 8'h56);
        step();
        check_all("ret");
        chk("ret/const_pred", F_predPC_o, 64'h41);
        set_bytes(8'h00, 8'h00, 8'h00, 8'h00);
        step();
        check_all("halt");
        chk("halt/const_stat", 64'(D_stat_o), 64'd2);
        set_bytes(8'hE0, 8'h00, 8'h00, 8'h00);
        step();
        check_all("invalid");
        chk("invalid/const_stat", 64'(D_stat_o), 64'd4);
        imem_error_i = 1'b1; set_bytes(8'h30, 8'h45, 8'hAA, 8'hBB);
        step();
        check_all("adr");
        chk("adr/const_stat", 64'(D_stat_o), 64'd3);
        imem_error_i = 1'b0;

        // Stall F and D for three cycles while pc/bytes change
        f_pc_i = 64'h60; set_bytes(8'h30, 8'hF3, 8'h10, 8'h00);
        step();
        ctl(1'b1, 1'b1, 1'b0);
        f_pc_i = 64'h200; set_bytes(8'h61, 8'h23, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) begin
            step();
            check_all("stall");
        end
        chk("stall/const_pred", F_predPC_o, 64'h6A);
        ctl(1'b0, 1'b0, 1'b1);
        step();
        check_all("bubble");
        chk("bubble/const_icode", 64'(D_icode_o), 64'h1);

        // Stall has priority over bubble
        ctl(1'b0, 1'b0, 1'b0);
        f_pc_i = 64'h300; set_bytes(8'h20, 8'h12, 8'h00, 8'h00);
        step();
        ctl(1'b0, 1'b1, 1'b1);
        f_pc_i = 64'h400; set_bytes(8'hA0, 8'h4F, 8'h00, 8'h00);
        step();
        check_all("stall_bubble");
        chk("stall_bubble/const_icode", 64'(D_icode_o), 64'h2);
        ctl(1'b0, 1'b0, 1'b0);

        // Asynchronous reset between edges
        #2 rst_n_i = 1'b0;
        #1 model_reset();
        check_all("async_rst");
        @(posedge clk_i); #1;
        check_all("rst_held");
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Randomized traffic, including pcs near the top of the address space
        for (int i = 0; i < 300; i++) begin
            f_pc_i = ($urandom_range(0, 7) == 0) ? {32'hFFFF_FFFF, 28'hFFFF_FFF, 4'($urandom)}
                                                 : {32'($urandom), 32'($urandom)};
            rand_bytes();
            b[0][7:4] = 4'($urandom_range(0, 15));
            imem_data_i[7:4] = b[0][7:4];
            imem_error_i = ($urandom_range(0, 9) == 0);
            ctl($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
            #1 chk("rand/imem_addr", imem_addr_o, f_pc_i);
            step();
            check_all("rand");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Fetch stage of the Y86-64 pipeline, including the F and D pipeline registers.
- Takes the selected fetch PC from the PC-select logic and reads instruction bytes from instruction memory.
- Splits and validates the instruction, then computes valP and the predicted next PC.
- Holds the predicted PC in the F register, which feeds back into PC select.
- Registers all fetched fields into the D register under pipeline-control stall/bubble.

Parameters:
- ADDR_W, 64, address/data width (matches `ADDR_BUS).
- IMEM_BYTES_W, 80, width of the instruction-memory read window (10 bytes).

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset. Asynchronous assert, active-low.
- f_pc_i  in  64  selected fetch PC from PC select.
- imem_addr_o  out  64  equals f_pc_i (combinational).
- imem_data_i  in  80  bytes [pc..pc+9]; byte k at bits [8k+7:8k].
- imem_error_i  in  1  address out of range.
- F_stall_i  in  1  hold F register.
- D_stall_i  in  1  hold D register.
- D_bubble_i  in  1  load NOP bubble into D.
- F_predPC_o  out  64  F register output.
- D_stat_o  out  3  status.
- D_icode_o  out  4  icode.
- D_ifun_o  out  4  ifun.
- D_rA_o  out  4  register A.
- D_rB_o  out  4  register B.
- D_valC_o  out  64  constant.
- D_valP_o  out  64  incremented PC.

Behaviour:
- Reset (rst_n_i low, async):
  - F_predPC_o = 0.
  - D_stat = AOK(1), D_icode = NOP(1), D_ifun = 0, D_rA = D_rB = RNONE(F), D_valC = D_valP = 0.
  - Outputs hold these values until the first rising edge after deassertion.
- Split (combinational):
  - icode = byte0[7:4], ifun = byte0[3:0].
  - If imem_error_i: icode is forced to NOP, ifun to 0.
- Validity: instr_valid = icode in 0x0..0xB.
- need_regids = icode in {RRMOVQ 2, IRMOVQ 3, RMMOVQ 4, MRMOVQ 5, OPQ 6, PUSHQ A, POPQ B}.
  - When set: rA = byte1[7:4], rB = byte1[3:0].
  - Otherwise rA = rB = F.
- need_valC = icode in {3, 4, 5, JXX 7, CALL 8}.
  - valC = little-endian 8 bytes starting at byte (1 + need_regids).
  - Otherwise valC = 0.
- valP = f_pc_i + 1 + need_regids + 8*need_valC.
  - Unsigned 64-bit; wraps modulo 2^64 with no flag.
- predPC = valC if icode is JXX or CALL, else valP.
  - Conditional jumps are always predicted taken.
- stat priority:
  1. imem_error_i → ADR(3).
  2. !instr_valid → INS(4).
  3. icode == HALT(0) → HLT(2).
  4. Otherwise AOK(1).
- F register, on posedge:
  - If F_stall_i: hold.
  - Else: load predPC.
- D register, on posedge:
  - If D_stall_i: hold. Stall takes priority over D_bubble_i when both are high.
  - Else if D_bubble_i: load the reset/bubble values.
  - Else: load stat, icode, ifun, rA, rB, valC, valP.
- Latency: one cycle from f_pc_i to D outputs and to F_predPC_o.
- Deferred to downstream stages:
  - Invalid, ADR or HLT fetches still propagate with their stat.
  - No fetch suppression happens here; pipeline control stalls F as needed.
- Reset asserted mid-operation: all registers go to reset values immediately, independent of stall/bubble.

Decomposition:
- define.v (shared):
  - icode constants: HALT, NOP, RRMOVQ, IRMOVQ, RMMOVQ, MRMOVQ, OPQ, JXX, CALL, RET, PUSHQ, POPQ.
  - RNONE.
  - STAT_AOK/HLT/ADR/INS.
  - `ADDR_BUS, `ICODE_BUS, `STAT_BUS, `REG_BUS.
- Sub-module fetch_split_align: combinational.
  - Inputs: imem_data_i, imem_error_i.
  - Outputs: icode, ifun, rA, rB, valC, need_regids, need_valC, instr_valid.
- Top level holds valP/predPC/stat logic and both registers.

Test Plan:
1. pc=0x0, bytes 30 F3 10 00.. (irmovq $0x10,%rbx) → next edge: D_icode=3, rA=F, rB=3, valC=0x10, valP=0xA, F_predPC=0xA, stat=1.
2. pc=0x20, bytes 70 00 01 00.. (jmp 0x100) → D_valP=0x29, F_predPC=0x100. Repeat with 80 (call) → same pair.
3. pc=0x40, byte 90 (ret) → valP=0x41, predPC=0x41, rA=rB=F. Byte 00 (halt) → stat=2.
4. Byte E0 → stat=4, icode=E. imem_error_i=1 with any data → stat=3, icode=1.
5. Load instr, then F_stall_i=D_stall_i=1 for 3 cycles with a new f_pc_i → F_predPC and D outputs unchanged. Assert D_bubble_i with D_stall_i=0 → D_icode=1, rA=rB=F, stat=1.
6. Assert rst_n_i low mid-cycle, between edges → outputs reach reset values without a clock edge. Stall+bubble both high → D holds.
